// File: rtl/fnsc_serial_adder_ctrl_pkg.sv
// Shared types and constants for the Fibonacci-numeral serial adder sequencer.
package fnsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Combinational depth of the adder cell; kept so the sequencer can be pipelined later.
  localparam int unsigned FNSC_CELL_STAGES = 1;

endpackage

// File: rtl/fnsc_serial_adder_ctrl_cell.sv
// Single-bit Fibonacci-numeral adder cell; err_flag routes around a faulty wire position.
module Adder_f02 (
  input  logic A_in,
  input  logic B_in,
  input  logic err_flag,
  output logic S_out,
  output logic B_out
);

  assign S_out = err_flag ? B_in : (A_in ^ B_in);
  assign B_out = err_flag ? A_in : B_in;

endmodule

// File: rtl/fnsc_serial_adder_ctrl.sv
// Bit-serial sequencer stepping one Adder_f02 cell across an N-bit codeword
// with a per-position fault mask.
module fnsc_serial_adder_ctrl
  import fnsc_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [N-1:0] cfg_mask,
  output logic         cfg_rej,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic         in_b0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_b,
  output logic         busy
);

  localparam logic [CW-1:0] POS_LAST = CW'(N - 1);

  state_e        state;
  state_e        state_nxt;
  logic [N-1:0]  mask;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  m_sr;
  logic [N-1:0]  s_reg;
  logic          b_reg;
  logic [CW-1:0] pos;
  logic          cfg_rej_q;

  logic          accept_c;
  logic          last_c;
  logic          cell_err_c;
  logic          cell_s_c;
  logic          cell_b_c;

  assign accept_c   = in_valid & (state == IDLE);
  assign last_c     = (pos == POS_LAST);
  assign cell_err_c = m_sr[0] & (state == RUN);

  Adder_f02 u_cell (
    .A_in     (a_sr[0]),
    .B_in     (b_reg),
    .err_flag (cell_err_c),
    .S_out    (cell_s_c),
    .B_out    (cell_b_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)  state_nxt = RUN;
      RUN:     if (last_c)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: mask config, operand shifting and result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask      <= '0;
      a_sr      <= '0;
      m_sr      <= '0;
      s_reg     <= '0;
      b_reg     <= 1'b0;
      pos       <= '0;
      cfg_rej_q <= 1'b0;
    end else begin
      cfg_rej_q <= cfg_we & (state != IDLE);
      if (cfg_we && (state == IDLE)) mask <= cfg_mask;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= in_a;
            b_reg <= in_b0;
            // Write-first: a same-cycle config write applies to the accepted word.
            m_sr  <= cfg_we ? cfg_mask : mask;
            pos   <= '0;
          end
        end
        RUN: begin
          s_reg[pos] <= cell_s_c;
          b_reg      <= cell_b_c;
          a_sr       <= a_sr >> 1;
          m_sr       <= m_sr >> 1;
          if (!last_c) pos <= pos + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_s     = s_reg;
  assign out_b     = b_reg;
  assign cfg_rej   = cfg_rej_q;

endmodule

// File: tb/tb_fnsc_serial_adder_ctrl.sv
// Directed + randomized self-checking bench for fnsc_serial_adder_ctrl at N=4.
module tb_fnsc_serial_adder_ctrl;

  localparam int unsigned N   = 4;
  localparam int          TMO = 40;

  logic         clk;
  logic         rst_n;
  logic         cfg_we;
  logic [N-1:0] cfg_mask;
  logic         cfg_rej;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic         in_b0;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_s;
  logic         out_b;
  logic         busy;

  int n_pass;
  int n_total;
  logic [N-1:0] model_mask;

  fnsc_serial_adder_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .cfg_rej   (cfg_rej),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b0     (in_b0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_b     (out_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the codeword position by position; returns {b_N, s}.
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic b0,
                                         input logic [N-1:0] m);
    logic         b;
    logic [N-1:0] s;
    b = b0;
    s = '0;
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        s[k] = b;
        b    = a[k];
      end else begin
        s[k] = a[k] ^ b;
      end
    end
    return {b, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int c;
    c = 0;
    while (!in_ready && c < TMO) begin
      step();
      c++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One transaction; optional IDLE write-first, optional rejected write in RUN,
  // optional consumer stall of `hold` cycles in DONE.
  task automatic do_word(input logic [N-1:0] a, input logic b0, input bit wr,
                         input logic [N-1:0] wm, input bit run_wr, input int hold,
                         input string tag);
    logic [N:0] exp;
    int lat;
    wait_ready(tag);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_a      = a;
    in_b0     = b0;
    cfg_we    = wr;
    cfg_mask  = wm;
    if (wr) model_mask = wm;
    exp = ref_add(a, b0, model_mask);
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat = 0;
    if (run_wr) begin
      cfg_we   = 1'b1;
      cfg_mask = ~model_mask;
      step();
      cfg_we = 1'b0;
      lat = 1;
      chk({tag, "_rej_pulse"}, 32'(cfg_rej), 32'd1);
    end
    while (!out_valid && lat < TMO) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    chk({tag, "_s"}, 32'(out_s), 32'(exp[N-1:0]));
    chk({tag, "_b"}, 32'(out_b), 32'(exp[N]));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rej_idle"}, 32'(cfg_rej), 32'd0);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_a     = ~a;
      in_b0    = ~b0;
      for (int i = 0; i < hold; i++) begin
        step();
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_s"}, 32'(out_s), 32'(exp[N-1:0]));
        chk({tag, "_hold_b"}, 32'(out_b), 32'(exp[N]));
        chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [N:0] e;
  logic [N:0] expq[$];
  int last_acc;
  int seen_valid;
  bit acc;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_mask = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b0 = 1'b0;
    out_ready = 1'b1;
    model_mask = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_rej", 32'(cfg_rej), 32'd0);
    chk("rst_out_s", 32'(out_s), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);

    do_word(4'b1010, 1'b1, 1'b0, '0, 1'b0, 0, "w_mask0");

    cfg_we = 1'b1;
    cfg_mask = 4'b0010;
    model_mask = 4'b0010;
    step();
    cfg_we = 1'b0;
    chk("idle_cfg_no_rej", 32'(cfg_rej), 32'd0);
    do_word(4'b0110, 1'b0, 1'b0, '0, 1'b0, 0, "w_mask2");

    do_word(N'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 3, "w_hold");

    do_word(N'($urandom), 1'($urandom), 1'b0, '0, 1'b1, 0, "w_run_rej");
    do_word(N'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 0, "w_old_mask");
    do_word(4'b0011, 1'b0, 1'b1, 4'b1111, 1'b0, 0, "w_wr_first");

    // Reset while the cell is at position 2.
    wait_ready("mid_rst");
    in_valid = 1'b1;
    in_a = N'($urandom);
    in_b0 = 1'($urandom);
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_mask = '0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < N + 2; i++) begin
      step();
      if (out_valid) seen_valid++;
    end
    chk("mid_rst_no_output", 32'(seen_valid), 32'd0);
    do_word(4'b1111, 1'b0, 1'b0, '0, 1'b0, 0, "w_mask_cleared");

    for (int j = 0; j < 4; j++)
      do_word(N'($urandom), 1'($urandom), 1'($urandom), N'($urandom), 1'b0, 0, "w_rand");

    // Back-to-back stream with the consumer always ready.
    cfg_we = 1'b1;
    cfg_mask = N'($urandom);
    model_mask = cfg_mask;
    step();
    cfg_we = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = N'($urandom);
    in_b0 = 1'($urandom);
    last_acc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("b2b_s", 32'(out_s), 32'(e[N-1:0]));
          chk("b2b_b", 32'(out_b), 32'(e[N]));
        end else begin
          chk("b2b_spurious", 32'(out_valid), 32'd0);
        end
      end
      acc = in_ready;
      if (acc) begin
        expq.push_back(ref_add(in_a, in_b0, model_mask));
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'(N + 2));
        last_acc = cyc;
      end
      step();
      if (acc) begin
        in_a = N'($urandom);
        in_b0 = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2 * N + 4 && expq.size() > 0; i++) begin
      if (out_valid) begin
        e = expq.pop_front();
        chk("b2b_drain_s", 32'(out_s), 32'(e[N-1:0]));
        chk("b2b_drain_b", 32'(out_b), 32'(e[N]));
      end
      step();
    end
    chk("b2b_all_out", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
